// File: rtl/ram_sync_hs.sv
`default_nettype none
// ============================================================================
//  Module      : ram_sync_hs
//  Description : Byte-addressed big-endian synchronous RAM with a four-phase
//                Enable/MFC handshake and programmable response latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_sync_hs #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2,
    parameter int ALIGN_CHECK = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Enable,
    input  logic              ReadWrite,
    input  logic [ADDR_W-1:0] Address,
    input  logic [1:0]        DataSize,
    input  logic [63:0]       DataIn,
    output logic [63:0]       DataOut,
    output logic              MFC,
    output logic              AddrErr,
    output logic              Busy
);

    localparam int         c_DEPTH = 1 << ADDR_W;
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [7:0]        r_mem [c_DEPTH];
    logic [1:0]        r_state;
    logic [7:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rw;
    logic [1:0]        r_size;
    logic [63:0]       r_din;
    logic [63:0]       r_dout;
    logic              r_mfc;
    logic              r_err;
    logic              r_busy;

    logic [3:0]        w_nbytes;
    logic [2:0]        w_mask;
    logic              w_misalign;
    logic              w_access;
    logic              w_wr_en;
    logic [6:0]        w_shift;
    logic [63:0]       w_wdata;
    logic [63:0]       w_rdata;
    logic [ADDR_W-1:0] w_baddr [8];

    always_comb begin
        w_nbytes   = 4'd1 << r_size;
        w_mask     = 3'(w_nbytes - 4'd1);
        w_misalign = (ALIGN_CHECK != 0) && ((3'(r_addr) & w_mask) != 3'd0);
        w_access   = (r_state == c_WAIT) && (r_cnt == 8'd0);
        w_wr_en    = w_access && !Reset && !r_rw && !w_misalign;
        // Left-justify the item so byte i of the item always sits at [63-8i -: 8]
        w_shift    = 7'd64 - {w_nbytes, 3'b000};
        w_wdata    = r_din << w_shift;
        w_rdata    = '0;
        for (int i = 0; i < 8; i++) begin
            w_baddr[i] = r_addr + ADDR_W'(i);
            if (4'(i) < w_nbytes)
                w_rdata = (w_rdata << 8) | {56'd0, r_mem[w_baddr[i]]};
        end
    end

    // Storage has no reset: contents survive Reset by design
    always_ff @(posedge Clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < w_nbytes)
                    r_mem[w_baddr[i]] <= w_wdata[63-8*i -: 8];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_rw    <= 1'b0;
            r_size  <= '0;
            r_din   <= '0;
            r_dout  <= '0;
            r_mfc   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (Enable) begin
                        r_addr  <= Address;
                        r_rw    <= ReadWrite;
                        r_size  <= DataSize;
                        r_din   <= DataIn;
                        r_cnt   <= 8'(WAIT_STATES);
                        r_busy  <= 1'b1;
                        r_state <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        r_mfc   <= 1'b1;
                        r_state <= c_DONE;
                        if (w_misalign)
                            r_err <= 1'b1;
                        else if (r_rw)
                            r_dout <= w_rdata;
                    end
                end
                c_DONE: begin
                    if (!Enable) begin
                        r_mfc   <= 1'b0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign DataOut = r_dout;
    assign MFC     = r_mfc;
    assign AddrErr = r_err;
    assign Busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ram_sync_hs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_sync_hs
//  Description : Self-checking bench for ram_sync_hs over three configurations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_sync_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst, en, rw, mfc, aerr, busy;
    logic [2:0][7:0]  addr;
    logic [2:0][1:0]  sz;
    logic [2:0][63:0] din, dout;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: flat byte array per instance plus last read result
    logic [7:0]  mem_m [3][256];
    logic [63:0] last_dout [3];
    int          ws_of [3] = '{2, 3, 0};
    bit          ac_of [3] = '{1'b1, 1'b1, 1'b0};

    ram_sync_hs #(.ADDR_W(8), .WAIT_STATES(2), .ALIGN_CHECK(1)) u_dut0 (
        .Clk(clk), .Reset(rst[0]), .Enable(en[0]), .ReadWrite(rw[0]),
        .Address(addr[0]), .DataSize(sz[0]), .DataIn(din[0]),
        .DataOut(dout[0]), .MFC(mfc[0]), .AddrErr(aerr[0]), .Busy(busy[0]));

    ram_sync_hs #(.ADDR_W(8), .WAIT_STATES(3), .ALIGN_CHECK(1)) u_dut1 (
        .Clk(clk), .Reset(rst[1]), .Enable(en[1]), .ReadWrite(rw[1]),
        .Address(addr[1]), .DataSize(sz[1]), .DataIn(din[1]),
        .DataOut(dout[1]), .MFC(mfc[1]), .AddrErr(aerr[1]), .Busy(busy[1]));

    ram_sync_hs #(.ADDR_W(8), .WAIT_STATES(0), .ALIGN_CHECK(0)) u_dut2 (
        .Clk(clk), .Reset(rst[2]), .Enable(en[2]), .ReadWrite(rw[2]),
        .Address(addr[2]), .DataSize(sz[2]), .DataIn(din[2]),
        .DataOut(dout[2]), .MFC(mfc[2]), .AddrErr(aerr[2]), .Busy(busy[2]));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full handshake on instance d, checked against the model.
    task automatic xact(input int d, input bit r, input logic [7:0] a, input logic [1:0] s,
                        input logic [63:0] wd, input bit drop, input int hold,
                        output logic [63:0] rdv);
        int          nb, lat;
        bit          mis;
        logic [63:0] v, exp_d;
        logic        got_e;
        nb  = 1 << s;
        mis = ac_of[d] && ((int'(a) % nb) != 0);
        v   = '0;
        for (int i = 0; i < nb; i++)
            v = (v << 8) | 64'(mem_m[d][(int'(a) + i) % 256]);
        exp_d = (mis || !r) ? last_dout[d] : v;

        @(negedge clk);
        en[d] = 1'b1; rw[d] = r; addr[d] = a; sz[d] = s; din[d] = wd;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                check_eq("busy_wait", 64'(busy[d]), 64'd1);
                din[d]  = {$urandom, $urandom};
                addr[d] = 8'($urandom);
                sz[d]   = 2'($urandom);
                rw[d]   = 1'($urandom);
                if (drop) en[d] = 1'b0;
            end
        end while (!mfc[d] && lat < 300);
        check_eq("latency", 64'(lat), 64'(ws_of[d] + 2));
        rdv   = dout[d];
        got_e = aerr[d];
        check_eq("dataout", rdv, exp_d);
        check_eq("addrerr", 64'(got_e), 64'(mis));
        check_eq("busy_done", 64'(busy[d]), 64'd1);
        if (!drop) begin
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                check_eq("mfc_hold", 64'(mfc[d]), 64'd1);
                check_eq("dout_hold", dout[d], exp_d);
            end
            en[d] = 1'b0;
        end
        @(negedge clk);
        check_eq("mfc_fall", 64'(mfc[d]), 64'd0);
        check_eq("busy_fall", 64'(busy[d]), 64'd0);
        check_eq("err_fall", 64'(aerr[d]), 64'd0);

        if (!r && !mis)
            for (int i = 0; i < nb; i++)
                mem_m[d][(int'(a) + i) % 256] = 8'(wd >> (8 * (nb - 1 - i)));
        last_dout[d] = exp_d;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] rv;
        rst = '1; en = '0; rw = '0; addr = '0; sz = '0; din = '0;
        for (int d = 0; d < 3; d++) last_dout[d] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_eq("rst_dout", dout[d], 64'd0);
            check_eq("rst_mfc", 64'(mfc[d]), 64'd0);
            check_eq("rst_err", 64'(aerr[d]), 64'd0);
            check_eq("rst_busy", 64'(busy[d]), 64'd0);
        end
        rst = '0;

        // Fill every instance so the model knows all bytes
        for (int d = 0; d < 3; d++)
            for (int j = 0; j < 32; j++)
                xact(d, 1'b0, 8'(8 * j), 2'b11, {$urandom, $urandom}, 1'b0, 0, rv);

        // Reset in the middle of a write must suppress it
        xact(0, 1'b0, 8'h20, 2'b00, 64'h00, 1'b0, 0, rv);
        @(negedge clk);
        en[0] = 1'b1; rw[0] = 1'b0; addr[0] = 8'h20; sz[0] = 2'b00; din[0] = 64'hAA;
        @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b1; en[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("midrst_dout", dout[0], 64'd0);
        check_eq("midrst_mfc", 64'(mfc[0]), 64'd0);
        check_eq("midrst_err", 64'(aerr[0]), 64'd0);
        check_eq("midrst_busy", 64'(busy[0]), 64'd0);
        rst[0] = 1'b0;
        last_dout[0] = '0;
        xact(0, 1'b1, 8'h20, 2'b00, 64'h0, 1'b0, 1, rv);
        check_eq("midrst_mem", rv, 64'h00);

        // Big-endian word/half/dword layout
        xact(0, 1'b0, 8'h10, 2'b10, 64'hFFFF_FFFF_1122_3344, 1'b0, 0, rv);
        xact(0, 1'b1, 8'h10, 2'b00, 64'h0, 1'b0, 0, rv); check_eq("be_b10", rv, 64'h11);
        xact(0, 1'b1, 8'h11, 2'b00, 64'h0, 1'b0, 0, rv); check_eq("be_b11", rv, 64'h22);
        xact(0, 1'b1, 8'h12, 2'b00, 64'h0, 1'b0, 0, rv); check_eq("be_b12", rv, 64'h33);
        xact(0, 1'b1, 8'h13, 2'b00, 64'h0, 1'b0, 0, rv); check_eq("be_b13", rv, 64'h44);
        xact(0, 1'b1, 8'h12, 2'b01, 64'h0, 1'b0, 0, rv); check_eq("be_h12", rv, 64'h3344);
        xact(0, 1'b0, 8'h18, 2'b11, 64'h0102_0304_0506_0708, 1'b0, 0, rv);
        xact(0, 1'b1, 8'h18, 2'b11, 64'h0, 1'b0, 2, rv); check_eq("be_d18", rv, 64'h0102_0304_0506_0708);
        xact(0, 1'b1, 8'h1C, 2'b10, 64'h0, 1'b0, 0, rv); check_eq("be_w1c", rv, 64'h0506_0708);

        // Latency with three wait states, held MFC
        xact(1, 1'b1, 8'h18, 2'b11, 64'h0, 1'b0, 3, rv);

        // Misaligned half write is rejected, neighbours untouched
        xact(0, 1'b0, 8'h03, 2'b01, 64'hBEEF, 1'b0, 1, rv);
        xact(0, 1'b1, 8'h03, 2'b00, 64'h0, 1'b0, 0, rv);
        xact(0, 1'b1, 8'h04, 2'b00, 64'h0, 1'b0, 0, rv);

        // Unchecked alignment wraps around the top of memory
        xact(2, 1'b0, 8'hFE, 2'b10, 64'hDEAD_BEEF, 1'b0, 0, rv);
        xact(2, 1'b1, 8'hFE, 2'b00, 64'h0, 1'b0, 0, rv); check_eq("wrap_fe", rv, 64'hDE);
        xact(2, 1'b1, 8'hFF, 2'b00, 64'h0, 1'b0, 0, rv); check_eq("wrap_ff", rv, 64'hAD);
        xact(2, 1'b1, 8'h00, 2'b00, 64'h0, 1'b0, 0, rv); check_eq("wrap_00", rv, 64'hBE);
        xact(2, 1'b1, 8'h01, 2'b00, 64'h0, 1'b0, 0, rv); check_eq("wrap_01", rv, 64'hEF);

        // Early Enable drop; DataIn is scrambled after acceptance inside xact
        xact(1, 1'b0, 8'h40, 2'b10, 64'hCAFE_F00D, 1'b1, 0, rv);
        xact(1, 1'b1, 8'h40, 2'b10, 64'h0, 1'b0, 0, rv); check_eq("drop_wr", rv, 64'hCAFE_F00D);
        xact(2, 1'b0, 8'h41, 2'b01, 64'h1234, 1'b1, 0, rv);
        xact(2, 1'b1, 8'h41, 2'b01, 64'h0, 1'b1, 0, rv); check_eq("drop_ws0", rv, 64'h1234);

        for (int n = 0; n < 100; n++)
            for (int d = 0; d < 3; d++)
                xact(d, 1'($urandom), 8'($urandom), 2'($urandom), {$urandom, $urandom},
                     ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), rv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
